// File: rtl/multi_bank_sync_fifo.sv
// Single-clock valid/ready FIFO with storage interleaved across NUM_BANKS banks,
// first-word-fall-through output, synchronous clear, level flags and high-water mark.
module multi_bank_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_BANKS  = 2,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LB_FIFO_DEPTH:0]  count,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [LB_FIFO_DEPTH:0]  max_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; ready/valid here depend only on registered count, never on the partner.

  localparam int CNT_W  = LB_FIFO_DEPTH + 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int ROWS   = FIFO_DEPTH / NUM_BANKS;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  logic [LB_FIFO_DEPTH-1:0] wr_ptr;
  logic [LB_FIFO_DEPTH-1:0] rd_ptr;
  logic [CNT_W-1:0]         count_next;
  logic [CNT_W-1:0]         max_next;
  logic                     push;
  logic                     pop;

  logic [BANK_W-1:0]        wr_bank;
  logic [BANK_W-1:0]        rd_bank;
  logic [ROW_W-1:0]         wr_row;
  logic [ROW_W-1:0]         rd_row;
  logic [DATA_WIDTH-1:0]    bank_rd [NUM_BANKS];

  assign in_ready     = (count != FULL_C);
  assign out_valid    = (count != '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A clear cycle swallows any handshake, so storage is not written either.
  assign push = in_valid && in_ready && !clear;
  assign pop  = out_valid && out_ready && !clear;

  // Low pointer bits pick the bank, the rest pick the row inside it.
  assign wr_bank = BANK_W'(wr_ptr % NUM_BANKS);
  assign rd_bank = BANK_W'(rd_ptr % NUM_BANKS);
  assign wr_row  = ROW_W'(wr_ptr / NUM_BANKS);
  assign rd_row  = ROW_W'(rd_ptr / NUM_BANKS);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (push && (wr_bank == BANK_W'(b))) begin
        mem[wr_row] <= in_data;
      end
    end

    assign bank_rd[b] = mem[rd_row];
  end

  assign out_data = bank_rd[rd_bank];

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count - CNT_W'(1);
    end
    max_next = (count_next > max_count) ? count_next : max_count;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LB_FIFO_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LB_FIFO_DEPTH'(1);
      end
      count     <= count_next;
      max_count <= max_next;
    end
  end

endmodule
